// File: rtl/priv_trap_ctrl.sv
// priv_trap_ctrl: precise trap/rti controller; optional trap_count port with PRIV_TRAP_COUNT_EN
module priv_trap_ctrl #(
    parameter logic [15:0] VECTOR_BASE  = 16'h0010,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Illegal_PC,
    input  logic        Illegal_Memory,
    input  logic [15:0] pc_fetch,
    input  logic [15:0] pc_mem,
    input  logic        syscall,
    input  logic [15:0] syscall_pc,
    input  logic        rti,
    input  logic [15:0] rti_pc,
    output logic        Mode,
    output logic        flush,
    output logic        trap_jump,
    output logic [15:0] trap_target,
    output logic [15:0] epc,
    output logic [1:0]  cause,
    output logic        busy
`ifdef PRIV_TRAP_COUNT_EN
    ,
    output logic [7:0]  trap_count
`endif
);
    typedef enum logic [1:0] {RUN, FLUSH, REDIRECT} state_t;
    localparam logic [2:0] FC_LAST = (FLUSH_CYCLES == 0) ? 3'd0 : 3'(FLUSH_CYCLES - 1);
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d, flush_q, flush_d, trap_jump_q, trap_jump_d, busy_q, busy_d;
    logic [15:0] trap_target_q, trap_target_d, epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic        ev_mem, ev_pc, ev_rti, enter_flush;
    assign ev_mem      = Illegal_Memory && !mode_q;
    assign ev_pc       = Illegal_PC && !mode_q;
    assign ev_rti      = rti && !mode_q;
    assign enter_flush = (state_q == RUN) && (ev_mem || ev_pc || syscall || ev_rti);
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        flush_d       = 1'b0;
        trap_jump_d   = 1'b0;
        trap_target_d = trap_target_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        busy_d        = 1'b0;
        case (state_q)
            RUN: begin
                if (enter_flush) begin
                    state_d = FLUSH;
                    cnt_d   = FC_LAST;
                    mode_d  = 1'b1;
                    flush_d = 1'b1;
                    busy_d  = 1'b1;
                    cause_d = ev_mem ? 2'd2 : ev_pc ? 2'd1 : syscall ? 2'd3 : 2'd0;
                    epc_d   = ev_mem ? pc_mem : ev_pc ? pc_fetch : syscall ? syscall_pc : rti_pc;
                end else if (rti) begin
                    trap_jump_d   = 1'b1;
                    trap_target_d = epc_q;
                    mode_d        = 1'b0;
                end
            end
            FLUSH: begin
                busy_d = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d       = REDIRECT;
                    trap_jump_d   = 1'b1;
                    trap_target_d = VECTOR_BASE + {12'd0, cause_q, 2'b00};
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= 3'd0;
            mode_q        <= 1'b1;
            flush_q       <= 1'b0;
            trap_jump_q   <= 1'b0;
            trap_target_q <= 16'h0000;
            epc_q         <= 16'h0000;
            cause_q       <= 2'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            flush_q       <= flush_d;
            trap_jump_q   <= trap_jump_d;
            trap_target_q <= trap_target_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            busy_q        <= busy_d;
        end
    end
    assign Mode        = mode_q;
    assign flush       = flush_q;
    assign trap_jump   = trap_jump_q;
    assign trap_target = trap_target_q;
    assign epc         = epc_q;
    assign cause       = cause_q;
    assign busy        = busy_q;
`ifdef PRIV_TRAP_COUNT_EN
    logic [7:0] trap_count_q, trap_count_d;
    always_comb trap_count_d = (enter_flush && trap_count_q != 8'hFF) ? trap_count_q + 8'd1 : trap_count_q;
    always_ff @(posedge clk) begin
        if (!rst_n) trap_count_q <= 8'd0;
        else        trap_count_q <= trap_count_d;
    end
    assign trap_count = trap_count_q;
`endif
endmodule
